// File: rtl/lc3_mem_unit.sv
// LC3 memory unit: MAR, MDR and word-addressed RAM behind a multi-cycle request/ready handshake.
// Optional macro LC3_MEM_CNT_EN adds saturating completed-read/write counters.
module lc3_mem_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  input  logic             ld_mar,
  input  logic             ld_mdr,
  input  logic             mem_req,
  input  logic             mem_we,
  output logic             mem_busy,
  output logic             mem_ready,
  output logic [WIDTH-1:0] mar_out,
  output logic [WIDTH-1:0] mdr_out,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;
  } req_t;

  logic [WIDTH-1:0] r_ram [DEPTH];
  state_t           r_state;
  state_t           w_state_nx;
  req_t             r_req;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mar;
  logic [WIDTH-1:0] r_mdr;
  logic             r_busy;
  logic             r_ready;
  logic             w_accept;
  logic             w_complete;

  // Next-state decode; w_complete marks the edge that performs the access.
  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_accept   = 1'b1;
          w_state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_complete = 1'b1;
          w_state_nx = S_DONE;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  // Request is snapshotted at acceptance so later MAR/MDR loads do not disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_req.we   <= mem_we;
      r_req.addr <= ADDR_WIDTH'(r_mar);
      r_req.data <= r_mdr;
      r_cnt      <= CNT_W'(LATENCY);
    end else if (r_state == S_BUSY && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Read completion data takes priority over a concurrent ld_mdr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      if (ld_mar) r_mar <= bus;
      if (w_complete && !r_req.we) r_mdr <= r_ram[r_req.addr];
      else if (ld_mdr)             r_mdr <= bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_complete && r_req.we) r_ram[r_req.addr] <= r_req.data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_busy  <= (w_state_nx != S_IDLE);
      r_ready <= (w_state_nx == S_DONE);
    end
  end

`ifdef LC3_MEM_CNT_EN
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else if (w_complete) begin
      if (!r_req.we && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (r_req.we && r_wr_cnt != 16'hFFFF)  r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

  assign mem_busy  = r_busy;
  assign mem_ready = r_ready;
  assign mar_out   = r_mar;
  assign mdr_out   = r_mdr;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Directed bench for lc3_mem_unit: one LATENCY=2 instance and one LATENCY=0 instance with 8 address bits.
module tb_lc3_mem_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] bus;
  logic        ld_mar;
  logic        ld_mdr;
  logic        req_a;
  logic        req_b;
  logic        we;

  logic        busy_a, ready_a, busy_b, ready_b;
  logic [15:0] mar_a, mdr_a, mar_b, mdr_b;
  logic [15:0] rdc_a, wrc_a, rdc_b, wrc_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_rd;
  logic [15:0] exp_wr;

  lc3_mem_unit #(.WIDTH(16), .ADDR_WIDTH(16), .LATENCY(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mem_req(req_a), .mem_we(we), .mem_busy(busy_a), .mem_ready(ready_a),
    .mar_out(mar_a), .mdr_out(mdr_a), .rd_count(rdc_a), .wr_count(wrc_a)
  );

  lc3_mem_unit #(.WIDTH(16), .ADDR_WIDTH(8), .LATENCY(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mem_req(req_b), .mem_we(we), .mem_busy(busy_b), .mem_ready(ready_b),
    .mar_out(mar_b), .mdr_out(mdr_b), .rd_count(rdc_b), .wr_count(wrc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full access on instance A: accept edge plus 4 more edges returns it to IDLE.
  task automatic access_a(input logic w);
    we    = w;
    req_a = 1'b1;
    tick();
    req_a = 1'b0;
    repeat (4) tick();
  endtask

  task automatic load(input logic m, input logic d, input logic [15:0] v);
    bus = v; ld_mar = m; ld_mdr = d;
    tick();
    ld_mar = 1'b0; ld_mdr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; bus = 16'hFFFF; ld_mar = 1'b1; ld_mdr = 1'b1;
    req_a = 1'b0; req_b = 1'b0; we = 1'b0;
    tick(); tick();
    chk("rst_mar", mar_a, 16'h0000);
    chk("rst_mdr", mdr_a, 16'h0000);
    chk("rst_ready", 16'(ready_a), 16'h0000);
    chk("rst_busy", 16'(busy_a), 16'h0000);
    chk("rst_rdcnt", rdc_a, 16'h0000);
    rst_n = 1'b1; ld_mar = 1'b0; ld_mdr = 1'b0;

    // Write BEEF to 3000 with timing trace
    load(1'b1, 1'b0, 16'h3000);
    load(1'b0, 1'b1, 16'hBEEF);
    we = 1'b1; req_a = 1'b1;
    tick();
    req_a = 1'b0;
    chk("wr_e0_busy", 16'(busy_a), 16'h0001);
    chk("wr_e0_ready", 16'(ready_a), 16'h0000);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("wr_e%0d_ready", i), 16'(ready_a), (i == 3) ? 16'h0001 : 16'h0000);
      chk($sformatf("wr_e%0d_busy", i), 16'(busy_a), (i <= 3) ? 16'h0001 : 16'h0000);
    end

    // Read it back after clearing MDR
    load(1'b0, 1'b1, 16'h0000);
    chk("rd_mdr_clr", mdr_a, 16'h0000);
    we = 1'b0; req_a = 1'b1;
    tick();
    req_a = 1'b0;
    tick(); tick();
    chk("rd_e2_mdr", mdr_a, 16'h0000);
    chk("rd_e2_ready", 16'(ready_a), 16'h0000);
    tick();
    chk("rd_e3_ready", 16'(ready_a), 16'h0001);
    chk("rd_e3_mdr", mdr_a, 16'hBEEF);
    tick();

    // Collision: MAR reload mid-access, ld_mdr on completion edge
    load(1'b1, 1'b0, 16'h0010);
    load(1'b0, 1'b1, 16'h1234);
    access_a(1'b1);
    we = 1'b0; req_a = 1'b1;
    tick();
    req_a = 1'b0;
    load(1'b1, 1'b0, 16'h0020);
    tick();
    bus = 16'h5555; ld_mdr = 1'b1;
    tick();
    ld_mdr = 1'b0;
    chk("col_ready", 16'(ready_a), 16'h0001);
    chk("col_mdr", mdr_a, 16'h1234);
    chk("col_mar", mar_a, 16'h0020);
    tick();

    // Seed RAM[5]=0001; the third completed write
    load(1'b1, 1'b0, 16'h0005);
    load(1'b0, 1'b1, 16'h0001);
    access_a(1'b1);
`ifdef LC3_MEM_CNT_EN
    exp_wr = 16'd3; exp_rd = 16'd2;
`else
    exp_wr = 16'd0; exp_rd = 16'd0;
`endif
    chk("wr_count", wrc_a, exp_wr);
    chk("rd_count", rdc_a, exp_rd);

    // Reset one edge after accepting a write of AAAA
    load(1'b0, 1'b1, 16'hAAAA);
    we = 1'b1; req_a = 1'b1;
    tick();
    req_a = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstmid_busy", 16'(busy_a), 16'h0000);
    chk("rstmid_mar", mar_a, 16'h0000);
    chk("rstmid_wrcnt", wrc_a, 16'h0000);
    load(1'b1, 1'b0, 16'h0005);
    access_a(1'b0);
    chk("rstmid_ram5", mdr_a, 16'h0001);

    // Instance B: LATENCY=0, 8 address bits, 0x0100 aliases word 0
    load(1'b1, 1'b0, 16'h0100);
    load(1'b0, 1'b1, 16'hCAFE);
    we = 1'b1; req_b = 1'b1;
    tick();
    req_b = 1'b0;
    chk("b_wr_e0_ready", 16'(ready_b), 16'h0000);
    chk("b_wr_e0_busy", 16'(busy_b), 16'h0001);
    tick();
    chk("b_wr_e1_ready", 16'(ready_b), 16'h0001);
    tick();
    chk("b_wr_e2_busy", 16'(busy_b), 16'h0000);
    load(1'b1, 1'b1, 16'h0000);
    chk("b_mdr_clr", mdr_b, 16'h0000);
    we = 1'b0; req_b = 1'b1;
    tick();
    chk("b_rd_e0_ready", 16'(ready_b), 16'h0000);
    tick();
    chk("b_rd_e1_ready", 16'(ready_b), 16'h0001);
    chk("b_rd_alias_mdr", mdr_b, 16'hCAFE);
    tick();
    chk("b_hold_e2_busy", 16'(busy_b), 16'h0000);
    chk("b_hold_e2_ready", 16'(ready_b), 16'h0000);
    tick();
    req_b = 1'b0;
    chk("b_hold_e3_busy", 16'(busy_b), 16'h0001);
    chk("b_hold_e3_ready", 16'(ready_b), 16'h0000);
    tick();
    chk("b_hold_e4_ready", 16'(ready_b), 16'h0001);
    tick();
    chk("b_hold_e5_busy", 16'(busy_b), 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
